// File: rtl/ball_motion_if.sv
// Signal bundle between the frame-timing/paddle side and the ball-motion engine.
interface ball_motion_if;
  logic       frame_tick;
  logic [9:0] paddle_x;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] miss_count;
  logic       serving;

  modport master (
    output frame_tick, paddle_x,
    input  ball_x, ball_y, dir_x, dir_y, hit_pulse, miss_pulse, miss_count, serving
  );

  modport slave (
    input  frame_tick, paddle_x,
    output ball_x, ball_y, dir_x, dir_y, hit_pulse, miss_pulse, miss_count, serving
  );
endinterface

// File: rtl/ball_motion.sv
// Ball-motion engine: per-frame stepping, wall/paddle reflection, miss handling and serve delay.
// Optional BALL_SPEEDUP_EN: each paddle hit grows both steps by one up to MAX_STEP.
module ball_motion #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 16,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_W    = 80,
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 4,
  parameter int MAX_STEP    = 12,
  parameter int START_X     = 320,
  parameter int START_Y     = 240,
  parameter int SERVE_DELAY = 60
) (
  input  logic         clk,
  input  logic         rst,
  ball_motion_if.slave bus
);

  localparam int          CNT_W   = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_BOT   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] Y_PAD   = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0]  X0      = 10'(START_X);
  localparam logic [9:0]  Y0      = 10'(START_Y);

  typedef enum logic {SERVE_WAIT, MOVE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic             hit_q, hit_d, miss_q, miss_d;
  logic [7:0]       mc_q, mc_d;
  logic [3:0]       step_x, step_y;

`ifdef BALL_SPEEDUP_EN
  logic [3:0] step_x_q, step_x_d, step_y_q, step_y_d;
  assign step_x = step_x_q;
  assign step_y = step_y_q;
`else
  assign step_x = 4'(STEP_X);
  assign step_y = 4'(STEP_Y);
`endif

  // Collision tests at 11 bits so no sum can wrap.
  logic [10:0] x11, y11, px11, sx11, sy11;
  logic        wall_l, wall_r, wall_t, overlap, pad_hit, bottom_miss, left_half;

  assign x11  = {1'b0, x_q};
  assign y11  = {1'b0, y_q};
  assign px11 = {1'b0, bus.paddle_x};
  assign sx11 = 11'(step_x);
  assign sy11 = 11'(step_y);

  assign wall_l      = !dx_q && (x11 <= sx11);
  assign wall_r      =  dx_q && (x11 + sx11 >= X_MAX);
  assign wall_t      = !dy_q && (y11 <= sy11);
  assign overlap     = (x11 + 11'(BALL_SIZE) > px11) && (x11 < px11 + 11'(PADDLE_W));
  assign pad_hit     = dy_q && (y11 + 11'(BALL_SIZE) + sy11 >= 11'(PADDLE_Y)) && overlap;
  assign bottom_miss = dy_q && (y11 + sy11 >= Y_BOT) && !pad_hit;
  assign left_half   = (x11 + 11'(BALL_SIZE / 2)) < (px11 + 11'(PADDLE_W / 2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    mc_d    = mc_q;
`ifdef BALL_SPEEDUP_EN
    step_x_d = step_x_q;
    step_y_d = step_y_q;
`endif
    if (bus.frame_tick) begin
      case (state_q)
        SERVE_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = MOVE;
            dx_d    = !dx_q;
            dy_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MOVE: begin
          if (bottom_miss) begin
            miss_d  = 1'b1;
            mc_d    = (mc_q == '1) ? mc_q : mc_q + 8'd1;
            x_d     = X0;
            y_d     = Y0;
            state_d = SERVE_WAIT;
            cnt_d   = '0;
`ifdef BALL_SPEEDUP_EN
            step_x_d = 4'(STEP_X);
            step_y_d = 4'(STEP_Y);
`endif
          end else begin
            if (wall_l) begin
              x_d  = '0;
              dx_d = 1'b1;
            end else if (wall_r) begin
              x_d  = X_MAX[9:0];
              dx_d = 1'b0;
            end else begin
              x_d = dx_q ? 10'(x11 + sx11) : 10'(x11 - sx11);
            end
            // Paddle sets dir_x last so it overrides any wall reflection this tick.
            if (pad_hit) begin
              y_d   = Y_PAD[9:0];
              dy_d  = 1'b0;
              dx_d  = !left_half;
              hit_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
              step_x_d = (step_x_q >= 4'(MAX_STEP)) ? 4'(MAX_STEP) : step_x_q + 4'd1;
              step_y_d = (step_y_q >= 4'(MAX_STEP)) ? 4'(MAX_STEP) : step_y_q + 4'd1;
`endif
            end else if (wall_t) begin
              y_d  = '0;
              dy_d = 1'b1;
            end else begin
              y_d = dy_q ? 10'(y11 + sy11) : 10'(y11 - sy11);
            end
          end
        end
        default: state_d = SERVE_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SERVE_WAIT;
      cnt_q   <= '0;
      x_q     <= X0;
      y_q     <= Y0;
      dx_q    <= 1'b0;
      dy_q    <= 1'b1;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      mc_q    <= '0;
`ifdef BALL_SPEEDUP_EN
      step_x_q <= 4'(STEP_X);
      step_y_q <= 4'(STEP_Y);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      mc_q    <= mc_d;
`ifdef BALL_SPEEDUP_EN
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
`endif
    end
  end

  assign bus.ball_x     = x_q;
  assign bus.ball_y     = y_q;
  assign bus.dir_x      = dx_q;
  assign bus.dir_y      = dy_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.miss_count = mc_q;
  assign bus.serving    = (state_q == SERVE_WAIT);

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed vector table, a SERVE_DELAY=1 instance, and model-scoreboarded random play.
module tb_ball_motion;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_motion_if bus ();
  ball_motion_if bus2 ();

  ball_motion dut (.clk(clk), .rst(rst), .bus(bus));
  ball_motion #(.SERVE_DELAY(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
    logic       hit;
    logic       miss;
    logic [7:0] mc;
    logic       srv;
  } obs_t;

  typedef struct {
    bit   r;
    bit   t;
    int   n;
    int   px;
    obs_t exp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  vec_t tbl[21];

  // Reference model state (default parameters written out as constants).
  int mx, my, mdx, mdy, msrv, mcnt, mmc, msx, msy;

  function automatic obs_t mk(int x, int y, bit dx, bit dy, bit hit, bit miss, int mc, bit srv);
    obs_t o;
    o.x = 10'(x); o.y = 10'(y); o.dx = dx; o.dy = dy;
    o.hit = hit; o.miss = miss; o.mc = 8'(mc); o.srv = srv;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(int'(bus.ball_x), int'(bus.ball_y), bus.dir_x, bus.dir_y,
              bus.hit_pulse, bus.miss_pulse, int'(bus.miss_count), bus.serving);
  endfunction

  task automatic chk(string name, int idx, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got x=%0d y=%0d dx=%0b dy=%0b hit=%0b miss=%0b mc=%0d srv=%0b required x=%0d y=%0d dx=%0b dy=%0b hit=%0b miss=%0b mc=%0d srv=%0b",
               name, idx, got.x, got.y, got.dx, got.dy, got.hit, got.miss, got.mc, got.srv,
               exp.x, exp.y, exp.dx, exp.dy, exp.hit, exp.miss, exp.mc, exp.srv);
    end
  endtask

  task automatic chk_val(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic model_step(bit r, bit t, int px);
    bit hit = 0, miss = 0;
    if (r) begin
      mx = 320; my = 240; mdx = 0; mdy = 1; msrv = 1; mcnt = 0; mmc = 0; msx = 4; msy = 4;
    end else if (t) begin
      if (msrv != 0) begin
        if (mcnt == 59) begin
          msrv = 0; mdx = (mdx == 0) ? 1 : 0; mdy = 1; mcnt = 0;
        end else mcnt++;
      end else begin
        int nx, ny, ndx, ndy;
        bit ov, ph;
        ov = (mx + 16 > px) && (mx < px + 80);
        ph = (mdy != 0) && (my + 16 + msy >= 440) && ov;
        if ((mdy != 0) && !ph && (my + msy >= 464)) begin
          miss = 1;
          mx = 320; my = 240; msrv = 1; mcnt = 0;
          mmc = (mmc < 255) ? mmc + 1 : 255;
          msx = 4; msy = 4;
        end else begin
          ndx = mdx; ndy = mdy;
          if (mdx != 0) begin
            nx = mx + msx;
            if (nx >= 624) begin nx = 624; ndx = 0; end
          end else begin
            nx = mx - msx;
            if (nx <= 0) begin nx = 0; ndx = 1; end
          end
          if (ph) begin
            ny = 424; ndy = 0; hit = 1;
            ndx = (mx + 8 >= px + 40) ? 1 : 0;
`ifdef BALL_SPEEDUP_EN
            msx = (msx < 12) ? msx + 1 : 12;
            msy = (msy < 12) ? msy + 1 : 12;
`endif
          end else if (mdy != 0) begin
            ny = my + msy;
          end else begin
            ny = my - msy;
            if (ny <= 0) begin ny = 0; ndy = 1; end
          end
          mx = nx; my = ny; mdx = ndx; mdy = ndy;
        end
      end
    end
    exp_q.push_back(mk(mx, my, mdx[0], mdy[0], hit, miss, mmc, msrv[0]));
  endtask

  // One clock: drive at negedge, predict, then compare the scoreboard head just after posedge.
  task automatic cycle(bit r, bit t, int px);
    obs_t e;
    @(negedge clk);
    rst = r;
    bus.frame_tick = t;
    bus.paddle_x = 10'(px);
    model_step(r, t, px);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard got empty queue required an entry");
    end else begin
      e = exp_q.pop_front();
      chk("sb", checks, sample(), e);
    end
  endtask

  task automatic set(int i, bit r, bit t, int n, int px, obs_t e);
    tbl[i] = '{r: r, t: t, n: n, px: px, exp: e};
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.paddle_x = '0;
    bus2.frame_tick = 1'b0;
    bus2.paddle_x = '0;

    set(0,  1, 0, 1,  0,   mk(320, 240, 0, 1, 0, 0, 0, 1));
    set(1,  0, 1, 59, 0,   mk(320, 240, 0, 1, 0, 0, 0, 1));
    set(2,  0, 1, 1,  0,   mk(320, 240, 1, 1, 0, 0, 0, 0));
    set(3,  0, 1, 1,  0,   mk(324, 244, 1, 1, 0, 0, 0, 0));
    set(4,  0, 1, 44, 450, mk(500, 420, 1, 1, 0, 0, 0, 0));
    set(5,  0, 1, 1,  450, mk(504, 424, 1, 0, 1, 0, 0, 0));
    set(6,  0, 0, 1,  450, mk(504, 424, 1, 0, 0, 0, 0, 0));
`ifdef BALL_SPEEDUP_EN
    set(7,  0, 1, 1,  450, mk(509, 419, 1, 0, 0, 0, 0, 0));
`else
    set(7,  0, 1, 1,  450, mk(508, 420, 1, 0, 0, 0, 0, 0));
`endif
    set(8,  1, 0, 1,  0,   mk(320, 240, 0, 1, 0, 0, 0, 1));
    set(9,  0, 1, 60, 480, mk(320, 240, 1, 1, 0, 0, 0, 0));
    set(10, 0, 1, 45, 480, mk(500, 420, 1, 1, 0, 0, 0, 0));
    set(11, 0, 1, 1,  480, mk(504, 424, 0, 0, 1, 0, 0, 0));
`ifdef BALL_SPEEDUP_EN
    set(12, 0, 1, 1,  480, mk(499, 419, 0, 0, 0, 0, 0, 0));
`else
    set(12, 0, 1, 1,  480, mk(500, 420, 0, 0, 0, 0, 0, 0));
`endif
    set(13, 1, 0, 1,  0,   mk(320, 240, 0, 1, 0, 0, 0, 1));
    set(14, 0, 1, 60, 0,   mk(320, 240, 1, 1, 0, 0, 0, 0));
    set(15, 0, 1, 55, 0,   mk(540, 460, 1, 1, 0, 0, 0, 0));
    set(16, 0, 1, 1,  0,   mk(320, 240, 1, 1, 0, 1, 1, 1));
    set(17, 0, 0, 1,  0,   mk(320, 240, 1, 1, 0, 0, 1, 1));
    set(18, 0, 1, 30, 0,   mk(320, 240, 1, 1, 0, 0, 1, 1));
    set(19, 1, 1, 1,  0,   mk(320, 240, 0, 1, 0, 0, 0, 1));
    set(20, 0, 1, 60, 0,   mk(320, 240, 1, 1, 0, 0, 0, 0));

    for (int i = 0; i < 21; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].r, tbl[i].t, tbl[i].px);
      chk("tbl", i, sample(), tbl[i].exp);
    end

    // SERVE_DELAY=1: the first tick after reset leaves serve, the next one moves.
    cycle(1, 0, 0);
    chk_val("sd1_reset_serving", int'(bus2.serving), 1);
    bus2.frame_tick = 1'b1;
    cycle(0, 0, 0);
    chk_val("sd1_serving_after_tick", int'(bus2.serving), 0);
    chk_val("sd1_dir_x", int'(bus2.dir_x), 1);
    chk_val("sd1_x_held", int'(bus2.ball_x), 320);
    cycle(0, 0, 0);
    chk_val("sd1_x_step", int'(bus2.ball_x), 324);
    chk_val("sd1_y_step", int'(bus2.ball_y), 244);
    bus2.frame_tick = 1'b0;

    // Random play: paddle mostly tracks the ball, changes every cycle, ticks are bursty.
    cycle(1, 0, 0);
    for (int i = 0; i < 6000; i++) begin
      int p;
      bit t;
      t = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, 1023));
      else begin
        p = mx + 20 - int'($urandom_range(0, 100));
        if (p < 0) p = 0;
      end
      cycle(($urandom_range(0, 799) == 0), t, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Parametrised ball-motion engine for the ping-pong game. On every frame tick it advances the ball position by a per-axis step, reflects off the left, right and top walls, and bounces off the paddle. The reflection direction depends on which half of the paddle is hit. A missed paddle triggers a serve delay and re-centres the ball. It sits between the frame-timing generator and the VGA renderer and replaces fixed-step, externally-sequenced ball control with self-contained collision handling.

## Interface
- `SCREEN_W`, 640, visible width in pixels
- `SCREEN_H`, 480, visible height in pixels
- `BALL_SIZE`, 16, ball edge length in pixels (square)
- `PADDLE_Y`, 440, y of paddle top edge
- `PADDLE_W`, 80, paddle width in pixels
- `STEP_X`, 4, base horizontal step per frame
- `STEP_Y`, 4, base vertical step per frame
- `MAX_STEP`, 12, step ceiling; used only with `BALL_SPEEDUP_EN`
- `START_X`, 320, serve x position
- `START_Y`, 240, serve y position
- `SERVE_DELAY`, 60, frame ticks spent in serve wait

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse per frame; all motion happens on it
- `paddle_x`  in  10  paddle left edge, sampled on `frame_tick`
- `ball_x`  out  10  ball left edge (registered)
- `ball_y`  out  10  ball top edge (registered)
- `dir_x`  out  1  1 = moving right
- `dir_y`  out  1  1 = moving down
- `hit_pulse`  out  1  one-cycle pulse on paddle bounce
- `miss_pulse`  out  1  one-cycle pulse on missed ball
- `miss_count`  out  8  misses since reset, saturating at 255
- `serving`  out  1  high while in SERVE_WAIT

## Operation
- States:
  - SERVE_WAIT: ball held at START_X/START_Y; frame-tick counter runs 0..SERVE_DELAY-1.
  - MOVE: ball advances on each frame tick.
- SERVE_WAIT -> MOVE on the tick where the counter equals SERVE_DELAY-1.
  - On this transition: `dir_y` = 1; `dir_x` toggles; the counter clears.
- Per-axis update on a tick in MOVE:
  - All sums are computed at 11 bits, so nothing wraps.
  - X and Y are evaluated independently in the same tick. A corner hit reflects both axes.
- Left wall: `dir_x`=0 and `ball_x` <= step_x -> `ball_x`=0, `dir_x`=1.
- Right wall: `dir_x`=1 and `ball_x`+step_x >= SCREEN_W-BALL_SIZE -> `ball_x`=SCREEN_W-BALL_SIZE, `dir_x`=0.
- Top wall: `dir_y`=0 and `ball_y` <= step_y -> `ball_y`=0, `dir_y`=1.
- Paddle test:
  - Condition: `dir_y`=1 and `ball_y`+BALL_SIZE+step_y >= PADDLE_Y and `ball_x`+BALL_SIZE > `paddle_x` and `ball_x` < `paddle_x`+PADDLE_W.
  - Effect: `ball_y`=PADDLE_Y-BALL_SIZE, `dir_y`=0, `hit_pulse`.
  - Direction: `dir_x` = 0 if the ball centre (`ball_x`+BALL_SIZE/2) < `paddle_x`+PADDLE_W/2, else 1. This overrides the wall x-reflection that tick.
- Paddle test has priority over the bottom test.
- Bottom/miss: `dir_y`=1 and `ball_y`+step_y >= SCREEN_H-BALL_SIZE with no paddle overlap:
  - Pulse `miss_pulse`; increment `miss_count` (saturating).
  - Load START_X/START_Y; enter SERVE_WAIT.
- Otherwise: position ± step per direction.
- `frame_tick` is ignored in no state other than as described; outside a tick all registers hold.

## Timing
- Reset values:
  - `ball_x`=START_X, `ball_y`=START_Y, `dir_x`=0, `dir_y`=1.
  - Pulses 0, `miss_count`=0, `serving`=1.
  - State SERVE_WAIT, counter 0, steps = STEP_X/STEP_Y.
- `rst` dominates `frame_tick` in the same cycle. Reset mid-flight returns to serve immediately.
- Latency: outputs reflect a tick one cycle after `frame_tick` is sampled high.
- `hit_pulse` and `miss_pulse` assert in that same cycle, for exactly one cycle.
- `paddle_x` is sampled only in the tick cycle; changes between ticks have no effect.
- Back-to-back ticks (every cycle) are legal and each advances one step.
- SERVE_DELAY=1: MOVE is entered on the first tick after serve entry.

## Configuration
- Macro: `BALL_SPEEDUP_EN`.
- Defined:
  - step_x and step_y are 4-bit registers.
  - Each paddle hit increments both by 1, saturating at MAX_STEP.
  - A miss or `rst` restores STEP_X/STEP_Y.
- Undefined: steps are the constants STEP_X/STEP_Y and MAX_STEP is ignored.

## Test plan
- Reset, then 60 ticks -> `serving` drops on tick 60; ball at (320,240) moving right-down at +4/+4 per tick.
- Ball at (8,100), `dir_x`=0, tick -> `ball_x`=4; next tick -> `ball_x`=0, `dir_x`=1; then 4, 8.
- Ball at (0,0), `dir_x`=0, `dir_y`=0, tick -> both directions flip; position (0,0) then (4,4).
- `paddle_x`=300, ball at (310,420) moving down-right, tick -> `ball_y`=424, `dir_y`=0, `dir_x`=0, `hit_pulse` for one cycle. Repeat with `ball_x`=350 -> `dir_x`=1.
- `paddle_x`=0, ball at (400,460) moving down, tick -> `miss_pulse`, `miss_count`=1, ball at (320,240), `serving`=1. Assert `rst` during a later serve -> `miss_count`=0.
- With `BALL_SPEEDUP_EN`: 10 consecutive paddle hits -> step reaches 12 and holds; after a miss, step returns to 4.
